uart2sample: RTL

//  Receive-side counterpart of the sample-to-UART serializer. Collects consecutive bytes from
//  the UART receiver, least-significant byte first, and assembles them into one BPS-bit sample.

---
 rtl/uart_sample_pkg.sv | 25 ++
 rtl/uart2sample_gap_timer.sv | 35 +++
 rtl/uart2sample.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_sample_pkg.sv
// Shared definitions for the UART byte-to-sample assembler: sizing helpers,
// default parameters and the assembly-side state encoding.
package uart_sample_pkg;

   localparam int DEFAULT_BPS            = 24;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   // Number of bytes that make up one sample of the given width.
   function automatic int nbytes(input int bps);
      return bps / 8;
   endfunction

   // Width of a byte index counting 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(nbytes(DEFAULT_BPS));

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/uart2sample_gap_timer.sv
// Inter-byte gap timer. Counts idle cycles while a partial sample is being
// collected and flags the cycle in which the idle count reaches the limit.
module gap_timer
   import uart_sample_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // A strobe in the same cycle always beats expiry, so clear masks it.
   assign expired = run & ~clear & (cnt == LAST);

   // Idle-cycle counter: restarts on every strobe, when not running, and on expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || !run || expired) begin
         cnt <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart2sample.sv
// Assembles consecutive UART bytes (LS byte first) into BPS-bit samples and
// hands them downstream over a valid/ready handshake. Partial samples are
// dropped on a framing error or when the inter-byte gap runs too long.
module uart2sample
   import uart_sample_pkg::*;
#(
   parameter int BPS            = DEFAULT_BPS,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic           in_clk,
   input  logic           in_rst_n,
   input  logic           in_rx_valid,
   input  logic [7:0]     in_rx_byte,
   input  logic           in_rx_error,
   input  logic           in_ready,
   output logic [BPS-1:0] out_sample,
   output logic           out_sample_valid,
   output logic           out_busy,
   output logic           out_overrun,
   output logic           out_timeout
);

   localparam int            NB       = nbytes(BPS);
   localparam int            IW       = idx_width(NB);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   state_t         state;
   logic [IW-1:0]  idx;
   logic [BPS-1:0] asm_q;
   logic [BPS-1:0] asm_next;
   logic           byte_ok;
   logic           complete;
   logic           consume;
   logic           expired;

   // An error in the same cycle as a byte discards that byte.
   assign byte_ok  = in_rx_valid & ~in_rx_error;
   assign complete = byte_ok & (idx == LAST_IDX);
   assign consume  = out_sample_valid & in_ready;
   assign out_busy = (state == COLLECT);

   // Assembly register with the incoming byte merged into its slot.
   always_comb begin
      // NOTE: the full default first keeps this block free of inferred latches.
      asm_next = asm_q;
      asm_next[{idx, 3'b000} +: 8] = in_rx_byte;
   end

   gap_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk     (in_clk),
      .rst_n   (in_rst_n),
      .run     (state == COLLECT),
      .clear   (in_rx_valid | in_rx_error),
      .expired (expired)
   );

   // Assembly FSM: byte index, state and partial-sample register.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state <= IDLE;
         idx   <= '0;
         // NOTE: the assembly register is reset so a discarded partial never leaks into a later sample.
         asm_q <= '0;
      end else if (in_rx_error) begin
         state <= IDLE;
         idx   <= '0;
         asm_q <= '0;
      end else if (in_rx_valid) begin
         if (complete) begin
            state <= IDLE;
            idx   <= '0;
            asm_q <= '0;
         end else begin
            state <= COLLECT;
            idx   <= idx + 1'b1;
            asm_q <= asm_next;
         end
      end else if (expired) begin
         state <= IDLE;
         idx   <= '0;
         asm_q <= '0;
      end
   end

   // Single-entry output register plus the overrun and timeout pulses.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_sample       <= '0;
         out_sample_valid <= 1'b0;
         out_overrun      <= 1'b0;
         out_timeout      <= 1'b0;
      end else begin
         out_overrun <= complete & out_sample_valid & ~in_ready;
         out_timeout <= expired;
         if (complete && (!out_sample_valid || consume)) begin
            out_sample       <= asm_next;
            out_sample_valid <= 1'b1;
         end else if (consume) begin
            out_sample_valid <= 1'b0;
         end
      end
   end

endmodule
